// File: rtl/wall_scheduler.sv
// Frame sequencer for the scrolling wall: erase old image, one UPDATE_WALL step, redraw with hole.
// Pixel outputs are combinational from state/raster counters; pause only defers frame start; WALL_SCHED_SCORE_EN adds scoring.
module wall_scheduler #(
    parameter int unsigned FRAME_TICKS = 833333,
    parameter int unsigned WALL_WIDTH  = 4,
    parameter int unsigned WALL_HEIGHT = 120,
    parameter int unsigned HOLE_HEIGHT = 50,
    parameter int unsigned SCREEN_W    = 160,
    parameter logic [2:0]  WALL_COLOUR = 3'b010,
    parameter logic [2:0]  BG_COLOUR   = 3'b000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic [7:0] wall_x,
    input  logic [7:0] hole_y,
    output logic [3:0] cur_state,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] colour,
    output logic       plot,
    output logic       frame_done,
    output logic       busy,
    output logic       overrun
`ifdef WALL_SCHED_SCORE_EN
    ,
    output logic [7:0] score,
    output logic       point
`endif
);

    localparam int PX_W = (WALL_WIDTH > 1) ? $clog2(WALL_WIDTH) : 1;

    typedef enum logic [3:0] {
        S_UPDATE = 4'd0,
        S_IDLE   = 4'd1,
        S_WAIT   = 4'd2,
        S_ERASE  = 4'd3,
        S_DRAW   = 4'd4
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [19:0]     r_frame_cnt;
    logic [PX_W-1:0] r_px;
    logic [6:0]      r_py;
    logic            r_pending;
    logic            r_overrun;
    logic [7:0]      r_draw_x;
    logic [7:0]      r_draw_hole;

    logic            w_tick;
    logic            w_raster;
    logic            w_px_last;
    logic            w_last;
    logic            w_first_draw;
    logic [7:0]      w_base_x;
    logic [7:0]      w_base_hole;
    logic [8:0]      w_x_sum;
    logic [8:0]      w_hole_end;
    logic            w_in_hole;

    assign w_tick       = (r_state != S_IDLE) && (r_frame_cnt == 20'(FRAME_TICKS - 1));
    assign w_raster     = (r_state == S_ERASE) || (r_state == S_DRAW);
    assign w_px_last    = (r_px == PX_W'(WALL_WIDTH - 1));
    assign w_last       = w_px_last && (r_py == 7'(WALL_HEIGHT - 1));
    assign w_first_draw = (r_state == S_DRAW) && (r_px == '0) && (r_py == '0);

    // ERASE replays the bases captured by the previous DRAW, so the old image is removed exactly
    assign w_base_x    = w_first_draw ? wall_x : r_draw_x;
    assign w_base_hole = w_first_draw ? hole_y : r_draw_hole;
    assign w_x_sum     = {1'b0, w_base_x} + 9'(r_px);
    assign w_hole_end  = {1'b0, w_base_hole} + 9'(HOLE_HEIGHT - 1);
    assign w_in_hole   = ({2'b00, r_py} >= {1'b0, w_base_hole}) && ({2'b00, r_py} <= w_hole_end);

    assign cur_state = r_state;
    assign x_out     = w_x_sum[7:0];
    assign y_out     = r_py;
    assign overrun   = r_overrun;

    always_comb begin
        w_next     = r_state;
        plot       = 1'b0;
        frame_done = 1'b0;
        busy       = 1'b0;
        colour     = BG_COLOUR;
        case (r_state)
            S_IDLE:   if (start) w_next = S_DRAW;
            S_WAIT:   if (!pause && (w_tick || r_pending)) w_next = S_ERASE;
            S_ERASE: begin
                busy = 1'b1;
                plot = (w_x_sum < 9'(SCREEN_W)) && !w_in_hole;
                if (w_last) w_next = S_UPDATE;
            end
            S_UPDATE: begin
                busy   = 1'b1;
                w_next = S_DRAW;
            end
            S_DRAW: begin
                busy       = 1'b1;
                colour     = WALL_COLOUR;
                plot       = (w_x_sum < 9'(SCREEN_W)) && !w_in_hole;
                frame_done = w_last;
                if (w_last) w_next = S_WAIT;
            end
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_frame_cnt <= '0;
            r_px        <= '0;
            r_py        <= '0;
            r_pending   <= 1'b0;
            r_overrun   <= 1'b0;
            r_draw_x    <= '0;
            r_draw_hole <= '0;
        end else begin
            r_state <= w_next;

            if ((r_state == S_IDLE) || w_tick) r_frame_cnt <= '0;
            else                               r_frame_cnt <= r_frame_cnt + 20'd1;

            // Only one frame is ever queued; a second tick while queued is flagged
            if ((r_state == S_WAIT) && (w_next == S_ERASE)) r_pending <= 1'b0;
            else if (w_tick)                                 r_pending <= 1'b1;
            if (w_tick && r_pending) r_overrun <= 1'b1;

            if (w_raster && !w_last) begin
                if (w_px_last) begin
                    r_px <= '0;
                    r_py <= r_py + 7'd1;
                end else begin
                    r_px <= r_px + PX_W'(1);
                end
            end else begin
                r_px <= '0;
                r_py <= '0;
            end

            if (w_first_draw) begin
                r_draw_x    <= wall_x;
                r_draw_hole <= hole_y;
            end
        end
    end

`ifdef WALL_SCHED_SCORE_EN
    localparam logic [7:0] WALL_SPEED_CMP = 8'd4;

    logic [7:0] r_score;
    logic       r_point;
    logic       w_score_hit;

    // Wall was at the left edge last frame and the datapath has just wrapped it off-screen
    assign w_score_hit = (r_state == S_UPDATE) && (r_draw_x < WALL_SPEED_CMP)
                         && ({1'b0, wall_x} >= 9'(SCREEN_W)) && (r_score != 8'hFF);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_score <= '0;
            r_point <= 1'b0;
        end else begin
            r_point <= w_score_hit;
            if (w_score_hit) r_score <= r_score + 8'd1;
        end
    end

    assign score = r_score;
    assign point = r_point;
`endif

endmodule

// File: tb/tb_wall_scheduler.sv
// Bench for wall_scheduler: vector table of wall/hole placements, pause/overrun and reset corner
// sequences, and a randomized run checked every cycle against a phase/elapsed-time reference model.
module tb_wall_scheduler;

    localparam int FT   = 1000;
    localparam int W    = 4;
    localparam int H    = 120;
    localparam int HH   = 50;
    localparam int SW   = 160;
    localparam int NPIX = W * H;

    localparam int P_UPD   = 0;
    localparam int P_IDLE  = 1;
    localparam int P_WAIT  = 2;
    localparam int P_ERASE = 3;
    localparam int P_DRAW  = 4;

    logic       clk = 1'b0;
    logic       reset, start, pause;
    logic [7:0] wall_x, hole_y;
    logic [3:0] cur_state;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour;
    logic       plot, frame_done, busy, overrun;

    wall_scheduler #(
        .FRAME_TICKS (FT),
        .WALL_WIDTH  (W),
        .WALL_HEIGHT (H),
        .HOLE_HEIGHT (HH),
        .SCREEN_W    (SW),
        .WALL_COLOUR (3'b010),
        .BG_COLOUR   (3'b000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pause      (pause),
        .wall_x     (wall_x),
        .hole_y     (hole_y),
        .cur_state  (cur_state),
        .x_out      (x_out),
        .y_out      (y_out),
        .colour     (colour),
        .plot       (plot),
        .frame_done (frame_done),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: phase, cycles spent in phase, cycles since leaving IDLE.
    int m_ph, m_el, m_cyc, m_pend, m_ovr, m_bx, m_bh, m_tick, m_nph;
    bit m_on = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_ph = P_IDLE; m_el = 0; m_cyc = 0; m_pend = 0; m_ovr = 0; m_bx = 0; m_bh = 0;
            m_on = 1'b1;
        end else if (m_on) begin
            m_tick = (m_ph != P_IDLE) && ((m_cyc % FT) == FT - 1);
            m_nph  = m_ph;
            case (m_ph)
                P_IDLE:  if (start) m_nph = P_DRAW;
                P_WAIT:  if (!pause && (m_tick || m_pend != 0)) m_nph = P_ERASE;
                P_ERASE: if (m_el == NPIX - 1) m_nph = P_UPD;
                P_UPD:   m_nph = P_DRAW;
                P_DRAW:  if (m_el == NPIX - 1) m_nph = P_WAIT;
                default: m_nph = P_IDLE;
            endcase
            if (m_ph == P_DRAW && m_el == 0) begin
                m_bx = int'(wall_x);
                m_bh = int'(hole_y);
            end
            if (m_tick != 0 && m_pend != 0) m_ovr = 1;
            if (m_ph == P_WAIT && m_nph == P_ERASE) m_pend = 0;
            else if (m_tick != 0)                   m_pend = 1;
            m_cyc = (m_ph == P_IDLE) ? 0 : m_cyc + 1;
            m_el  = (m_nph == m_ph) ? m_el + 1 : 0;
            m_ph  = m_nph;
        end
    end

    int  e_px, e_py, e_bx, e_bh, e_xs;
    bit  e_ras, e_plot;

    always @(negedge clk) begin
        if (m_on) begin
            e_px   = m_el % W;
            e_py   = m_el / W;
            e_bx   = (m_ph == P_DRAW && m_el == 0) ? int'(wall_x) : m_bx;
            e_bh   = (m_ph == P_DRAW && m_el == 0) ? int'(hole_y) : m_bh;
            e_xs   = e_bx + e_px;
            e_ras  = (m_ph == P_ERASE) || (m_ph == P_DRAW);
            e_plot = e_ras && (e_xs < SW) && !((e_py >= e_bh) && (e_py <= e_bh + HH - 1));
            chk("cur_state", int'(cur_state), m_ph);
            chk("plot", int'(plot), int'(e_plot));
            chk("busy", int'(busy), int'(m_ph == P_ERASE || m_ph == P_UPD || m_ph == P_DRAW));
            chk("frame_done", int'(frame_done), int'(m_ph == P_DRAW && m_el == NPIX - 1));
            chk("overrun", int'(overrun), m_ovr);
            chk("colour", int'(colour), (m_ph == P_DRAW) ? 2 : 0);
            if (e_ras) begin
                chk("x_out", int'(x_out), e_xs % 256);
                chk("y_out", int'(y_out), e_py);
            end
        end
    end

    // Driver side: every cycle goes through step(); it also plays the wall datapath when enabled.
    logic [3:0] prev_cs;
    bit         dp_en;

    task automatic step();
        @(posedge clk);
        #2;
        if (dp_en && prev_cs == 4'd0 && cur_state == 4'd4) begin
            if (wall_x < 8'd4) begin
                wall_x = 8'd160;
                hole_y = 8'($urandom_range(0, 119));
            end else begin
                wall_x = wall_x - 8'd4;
            end
        end
        prev_cs = cur_state;
    endtask

    task automatic count_pass(input int code, output int n, output bit ok);
        int guard;
        n = 0;
        guard = 0;
        while (int'(cur_state) != code && guard < 3000) begin
            step();
            guard++;
        end
        ok = (int'(cur_state) == code);
        while (int'(cur_state) == code && guard < 6000) begin
            if (plot) n++;
            step();
            guard++;
        end
    endtask

    typedef struct {
        int wx;
        int hy;
        int cnt;
    } vec_t;

    vec_t tbl [9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, time %0t, required completion", $time);
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end

    initial begin
        int  n;
        bit  ok;
        reset = 1'b1; start = 1'b0; pause = 1'b0; wall_x = 8'd0; hole_y = 8'd0;
        dp_en = 1'b0; prev_cs = 4'd1;

        tbl[0] = '{160,  30,   0};
        tbl[1] = '{100,  30, 280};
        tbl[2] = '{ 96,  30, 280};
        tbl[3] = '{158,  30, 140};
        tbl[4] = '{  0,   0, 280};
        tbl[5] = '{156, 100, 400};
        tbl[6] = '{  0, 200, 480};
        tbl[7] = '{159, 119, 119};
        tbl[8] = '{255,   0,   0};

        repeat (2) step();
        chk("rst_state", int'(cur_state), 1);
        chk("rst_x", int'(x_out), 0);
        chk("rst_y", int'(y_out), 0);
        chk("rst_plot", int'(plot), 0);
        chk("rst_colour", int'(colour), 0);
        chk("rst_done", int'(frame_done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ovr", int'(overrun), 0);

        for (int k = 0; k < 9; k++) begin
            reset = 1'b1; step(); reset = 1'b0;
            wall_x = 8'(tbl[k].wx);
            hole_y = 8'(tbl[k].hy);
            start  = 1'b1; step(); start = 1'b0;
            count_pass(P_DRAW, n, ok);
            chk("draw_seen", int'(ok), 1);
            chk("draw_plots", n, tbl[k].cnt);
            chk("after_draw_wait", int'(cur_state), P_WAIT);
            wall_x = 8'd160;
            hole_y = 8'd0;
            count_pass(P_ERASE, n, ok);
            chk("erase_seen", int'(ok), 1);
            chk("erase_plots", n, tbl[k].cnt);
            chk("update_state", int'(cur_state), P_UPD);
            step();
            chk("update_one_cycle", int'(cur_state), P_DRAW);
        end

        reset = 1'b1; step(); reset = 1'b0;
        wall_x = 8'd100; hole_y = 8'd100;
        start = 1'b1; step(); start = 1'b0;
        count_pass(P_DRAW, n, ok);
        chk("pause_draw_plots", n, 400);
        pause = 1'b1;
        repeat (1000) step();
        chk("pause_hold_1tick", int'(cur_state), P_WAIT);
        chk("ovr_after_1tick", int'(overrun), 0);
        repeat (1600) step();
        chk("pause_hold_3tick", int'(cur_state), P_WAIT);
        chk("ovr_after_3tick", int'(overrun), 1);
        pause = 1'b0;
        step();
        chk("resume_erase", int'(cur_state), P_ERASE);

        n = 0;
        while (cur_state != 4'd4 && n < 2000) begin
            step();
            n++;
        end
        chk("mid_draw_reached", int'(cur_state), P_DRAW);
        repeat (200) step();
        chk("mid_draw_plot", int'(plot), 1);
        chk("mid_draw_y", int'(y_out), 50);
        reset = 1'b1; step(); reset = 1'b0;
        chk("abort_plot", int'(plot), 0);
        chk("abort_state", int'(cur_state), P_IDLE);
        chk("abort_ovr", int'(overrun), 0);
        chk("abort_busy", int'(busy), 0);

        reset = 1'b1; step(); reset = 1'b0;
        dp_en  = 1'b1;
        wall_x = 8'($urandom_range(0, 40));
        hole_y = 8'($urandom_range(0, 70));
        start  = 1'b1;
        for (int c = 0; c < 12000; c++) begin
            step();
            start = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 199) == 0) pause = ~pause;
            if ($urandom_range(0, 49) == 0) hole_y = 8'($urandom_range(0, 119));
            reset = ($urandom_range(0, 3999) == 0);
        end
        reset = 1'b0;
        pause = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
